mem_packer: RTL and testbench
=============================

MEM_PACKER -- requirements
Module: mem_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the number of 32-bit words stored; it SHALL be a power of two.
REQ-002 SHALL have parameter ADDR_W, default 4, giving the address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port valid_in, input, 1 bit: byte strobe from the button/valid stage.
REQ-006 SHALL have port data_8, input, 8 bits: byte qualified by valid_in.
REQ-007 SHALL have port clear, input, 1 bit: synchronous flush of the packer and memory pointers.
REQ-008 SHALL have port rd_addr, input, ADDR_W bits: read address.
REQ-009 SHALL have port ready, output, 1 bit: the block accepts a byte this cycle.
REQ-010 SHALL have port rd_data, output, 32 bits: registered read data.
REQ-011 SHALL have port data_32, output, 32 bits: last word committed.
REQ-012 SHALL have port word_count, output, ADDR_W+1 bits: number of words stored.
REQ-013 SHALL have port memory_full, output, 1 bit: high when word_count equals DEPTH.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag for a byte dropped while full.

Function
REQ-015 A byte SHALL be accepted on a rising edge where valid_in=1 and ready=1.
REQ-016 ready SHALL equal NOT memory_full.
REQ-017 Packing SHALL be little-endian: the 1st accepted byte goes to bits [7:0], the 2nd to [15:8], the 3rd to [23:16], the 4th to [31:24].
REQ-018 A 2-bit byte counter SHALL track the packing position and wrap 3->0 on the 4th byte.
REQ-019 The FSM SHALL have four states:
- IDLE: byte counter 0.
- PACK: 1-3 bytes held.
- COMMIT: a one-cycle write.
- FULL.
REQ-020 FSM transitions SHALL be:
- IDLE->PACK on an accepted byte.
- PACK->COMMIT on the 4th accepted byte.
- COMMIT->FULL if word_count becomes DEPTH.
- COMMIT->PACK if a byte is accepted in COMMIT.
- COMMIT->IDLE otherwise.
- Any state->IDLE on clear.
REQ-021 In COMMIT, the assembled word SHALL be written to memory at wr_ptr, and copied to data_32, one cycle after the 4th byte is accepted.
REQ-022 In COMMIT, wr_ptr and word_count SHALL each increment by 1.
REQ-023 A byte accepted during COMMIT SHALL start the next word without loss (sustained one byte per cycle).
REQ-024 wr_ptr SHALL be ADDR_W bits wide and SHALL NOT wrap; storage stops at FULL.
REQ-025 In FULL, ready SHALL be 0.
REQ-026 A valid_in pulse while in FULL SHALL be dropped and SHALL set overflow, which holds until clear or reset.
REQ-027 clear SHALL zero the byte counter, wr_ptr, word_count and overflow, and SHALL empty the partial word.
REQ-028 clear SHALL NOT erase memory contents or data_32.
REQ-029 If clear and valid_in are asserted in the same cycle, clear SHALL win and the byte SHALL be discarded.
REQ-030 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is presented.
REQ-031 A read of the address being written in COMMIT SHALL return the old data (read-before-write).
REQ-032 A partial word (fewer than 4 bytes) SHALL never be written to memory.

Reset
REQ-033 When rst=0, asynchronously:
- FSM to IDLE.
- byte counter, wr_ptr and word_count to 0.
- data_32 and rd_data to 32'h0.
- memory_full and overflow to 0.
- ready to 1 once rst is released.
REQ-034 Memory array contents SHALL NOT be reset.
REQ-035 Reset asserted mid-word SHALL discard the partial word.

Structure
REQ-036 The FSM state encoding and the bytes-per-word constant (4) SHALL live in the shared package mem_driver_pkg.
REQ-037 Storage SHALL be the sub-module word_ram: DEPTH x 32, one synchronous write port, one synchronous read port, no reset.

Verification
REQ-038 Reset release, then bytes 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> next cycle mem[0]=32'h44332211, data_32=32'h44332211, word_count=1.
REQ-039 64 back-to-back bytes with DEPTH=16 -> memory_full=1 and ready=0 after the 16th COMMIT; mem[15] holds bytes 61-64; overflow=0.
REQ-040 One extra valid_in while full -> overflow=1, word_count stays 16; then clear -> overflow=0, memory_full=0, word_count=0, ready=1.
REQ-041 Three bytes, then rst=0 for one cycle, then 4 new bytes -> mem[0] holds only the 4 new bytes and word_count=1.
REQ-042 clear and valid_in with 8'hAA asserted in the same cycle -> byte discarded; the next 4 bytes form mem[0] without 8'hAA.
REQ-043 rd_addr=0 during COMMIT to address 0 -> rd_data returns the old value that cycle and the new word on the following read.

Source files
------------

// File: rtl/mem_driver_pkg.sv
// Shared definitions for the byte-to-word packer: FSM encoding and word geometry.
package mem_driver_pkg;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned ByteCntW     = $clog2(BytesPerWord);
  localparam int unsigned PartialW     = 8 * (BytesPerWord - 1);

  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(BytesPerWord - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StCommit,
    StFull
  } state_e;

endpackage

// File: rtl/word_ram.sv
// DEPTH x 32 storage: one synchronous write port, one synchronous read port, no reset.
module word_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];

  // Read samples the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/mem_packer.sv
// Packs accepted bytes little-endian into 32-bit words and stores them in word_ram
// until DEPTH words are held; further bytes are dropped and flagged as overflow.
module mem_packer
  import mem_driver_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [7:0]        data_8,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ready,
  output logic [31:0]       rd_data,
  output logic [31:0]       data_32,
  output logic [ADDR_W:0]   word_count,
  output logic              memory_full,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LastCount = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ByteCntW-1:0]   cnt_q, cnt_d;
  logic [PartialW-1:0]   part_q, part_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [31:0]           data_32_q, data_32_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_valid_q;
  logic                  we;
  logic                  accept;
  logic [31:0]           ram_rdata;

  assign memory_full = (count_q == FullCount);
  assign ready       = ~memory_full;
  assign accept      = valid_in & ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    part_d     = part_q;
    word_d     = word_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    data_32_d  = data_32_q;
    overflow_d = overflow_q | (valid_in & ~ready);
    we         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          part_d  = PartialW'(data_8);
          cnt_d   = ByteCntW'(1);
          state_d = StPack;
        end
      end
      StPack: begin
        if (accept) begin
          if (cnt_q == LastByte) begin
            word_d  = {data_8, part_q};
            cnt_d   = '0;
            state_d = StCommit;
          end else begin
            part_d[{cnt_q, 3'b000} +: 8] = data_8;
            cnt_d = cnt_q + ByteCntW'(1);
          end
        end
      end
      StCommit: begin
        we        = 1'b1;
        data_32_d = word_q;
        wr_ptr_d  = (wr_ptr_q == LastAddr) ? wr_ptr_q : wr_ptr_q + 1'b1;
        count_d   = count_q + 1'b1;
        if (count_q == LastCount) begin
          // The last slot is being consumed, so a byte arriving now has nowhere to go.
          overflow_d = overflow_d | valid_in;
          state_d    = StFull;
        end else if (accept) begin
          part_d  = PartialW'(data_8);
          cnt_d   = ByteCntW'(1);
          state_d = StPack;
        end else begin
          state_d = StIdle;
        end
      end
      StFull: begin
        state_d = StFull;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush wins over everything, including a pending commit; memory and data_32 are kept.
    if (clear) begin
      state_d    = StIdle;
      cnt_d      = '0;
      part_d     = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      data_32_d  = data_32_q;
      we         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      part_q     <= '0;
      word_q     <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      data_32_q  <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      part_q     <= part_d;
      word_q     <= word_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      data_32_q  <= data_32_d;
      overflow_q <= overflow_d;
      rd_valid_q <= 1'b1;
    end
  end

  word_ram #(
    .Depth (DEPTH),
    .AddrW (ADDR_W)
  ) u_word_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (word_q),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset, so read data is masked to zero until the first edge.
  assign rd_data    = rd_valid_q ? ram_rdata : 32'h0;
  assign data_32    = data_32_q;
  assign word_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mem_packer.sv
// Scoreboard bench for mem_packer: a byte-queue model predicts per-cycle outputs,
// a monitor pops and compares them on every falling edge.
module tb_mem_packer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid_in = 1'b0;
  logic [7:0]        data_8 = 8'h0;
  logic              clear = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              ready;
  logic [31:0]       rd_data;
  logic [31:0]       data_32;
  logic [ADDR_W:0]   word_count;
  logic              memory_full;
  logic              overflow;

  mem_packer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .data_8      (data_8),
    .clear       (clear),
    .rd_addr     (rd_addr),
    .ready       (ready),
    .rd_data     (rd_data),
    .data_32     (data_32),
    .word_count  (word_count),
    .memory_full (memory_full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd_chk;
    logic [31:0] rd;
    int          cnt;
    bit          full;
    bit          ovf;
    logic [31:0] d32;
  } exp_t;

  exp_t expq[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  bq[$];
  bit          pend = 0;
  logic [31:0] pend_word = '0;
  int          committed = 0;
  bit          ovf_m = 0;
  logic [31:0] d32_m = '0;
  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; the model predicts what the DUT shows after the next rising edge.
  task automatic step(input bit v, input logic [7:0] b, input bit clr, input bit rstn,
                      input logic [ADDR_W-1:0] ra);
    exp_t e;
    bit   full_before;
    @(negedge clk);
    #1;
    valid_in = v;
    data_8   = b;
    clear    = clr;
    rst      = rstn;
    rd_addr  = ra;
    if (!rstn) begin
      bq.delete();
      pend = 0; committed = 0; ovf_m = 0; d32_m = '0;
      e.rd_chk = 1; e.rd = '0;
    end else begin
      e.rd_chk = known[ra];
      e.rd     = mem_m[ra];
      full_before = (committed == DEPTH);
      if (clr) begin
        bq.delete();
        pend = 0; committed = 0; ovf_m = 0;
      end else begin
        if (pend) begin
          mem_m[committed] = pend_word;
          known[committed] = 1;
          d32_m = pend_word;
          committed++;
          pend = 0;
        end
        if (v) begin
          if (full_before || committed == DEPTH) begin
            ovf_m = 1;
          end else begin
            bq.push_back(b);
            if (bq.size() == 4) begin
              pend_word = {bq[3], bq[2], bq[1], bq[0]};
              bq.delete();
              pend = 1;
            end
          end
        end
      end
    end
    e.cnt  = committed;
    e.full = (committed == DEPTH);
    e.ovf  = ovf_m;
    e.d32  = d32_m;
    expq.push_back(e);
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] ra);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1, ra);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.rd_chk) chk("rd_data", rd_data, e.rd);
        chk("word_count", 32'(word_count), 32'(e.cnt));
        chk("memory_full", 32'(memory_full), 32'(e.full));
        chk("ready", 32'(ready), 32'(!e.full));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("data_32", data_32, e.d32);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      known[i] = 0;
      mem_m[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_data_32", data_32, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_memory_full", 32'(memory_full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);

    // First word, then read it back
    step(1, 8'h11, 0, 1, 4'd0);
    step(1, 8'h22, 0, 1, 4'd0);
    step(1, 8'h33, 0, 1, 4'd0);
    step(1, 8'h44, 0, 1, 4'd0);
    idle(3, 4'd0);

    // clear together with a byte: the byte is lost
    step(1, 8'hAA, 1, 1, 4'd0);
    step(1, 8'h01, 0, 1, 4'd0);
    step(1, 8'h02, 0, 1, 4'd0);
    step(1, 8'h03, 0, 1, 4'd0);
    step(1, 8'h04, 0, 1, 4'd0);
    // rd_addr=0 during the commit to address 0: old data, then new
    idle(3, 4'd0);

    // Fill all 16 words back to back
    step(0, 8'h00, 1, 1, 4'd0);
    for (int i = 1; i <= 64; i++) step(1, 8'(i), 0, 1, 4'($urandom_range(0, 15)));
    idle(2, 4'd15);
    step(1, 8'hEE, 0, 1, 4'd15);
    idle(2, 4'd15);
    step(0, 8'h00, 1, 1, 4'd15);
    idle(2, 4'd0);

    // Reset mid-word discards the partial word
    step(1, 8'hA1, 0, 1, 4'd0);
    step(1, 8'hA2, 0, 1, 4'd0);
    step(1, 8'hA3, 0, 1, 4'd0);
    step(0, 8'h00, 0, 0, 4'd0);
    step(1, 8'hB1, 0, 1, 4'd0);
    step(1, 8'hB2, 0, 1, 4'd0);
    step(1, 8'hB3, 0, 1, 4'd0);
    step(1, 8'hB4, 0, 1, 4'd0);
    idle(3, 4'd0);

    // Randomized traffic with gaps, occasional clears, random reads
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 79) == 0), 1,
           4'($urandom_range(0, 15)));
    end

    // Sweep every address
    for (int a = 0; a < DEPTH; a++) step(0, 8'h00, 0, 1, 4'(a));
    idle(2, 4'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
